fifo_rd_packer: RTL and testbench
=================================

// Module: fifo_rd_packer
// PURPOSE
//  Read-domain consumer of the asynchronous FIFO. Drains 1-word entries through the FIFO's
//  first-word-fall-through read port and packs PACK_WORDS consecutive words into one wide beat.
//  Presents each beat on a valid/ready output to the downstream r_clk-domain datapath.
//  A flush input emits a partially filled beat so trailing data is not stranded.
// PARAMETERS
//  DATA_BITS   10                       width of one FIFO word; equals the FIFO's DATA_BITS
//  PACK_WORDS  4                        words per output beat; must be >= 2
//  CNT_BITS    $clog2(PACK_WORDS+1)     width of idx and out_count
// PORTS
//  r_clk      in   1                     read-domain clock; single clock, all logic on posedge
//  r_reset    in   1                     synchronous, active-high reset
//  fifo_empty in   1                     FIFO empty flag (registered in FIFO)
//  fifo_read  out  1                     pop request to FIFO read port
//  fifo_data  in   DATA_BITS             FIFO head word; valid whenever fifo_empty==0
//  flush      in   1                     level, sampled each cycle; emit partial beat
//  out_valid  out  1                     beat valid
//  out_ready  in   1                     downstream accept
//  out_data   out  DATA_BITS*PACK_WORDS  packed beat; word 0 in LSBs
//  out_count  out  CNT_BITS              number of valid words in beat (1..PACK_WORDS)
// BEHAVIOUR
//  - Reset (r_reset==1 at posedge): state=PK_FILL, idx=0, out_valid=0, out_data=0, out_count=0.
//    fifo_read is forced 0 while r_reset==1. Reset mid-beat discards all packed words.
//  - fifo_read = (state==PK_FILL) & ~fifo_empty & ~r_reset. This is combinational; the FIFO pops
//    on the same edge.
//  - PK_FILL, edge with fifo_read=1: lane[idx] <= fifo_data; idx <= idx+1.
//    - If idx==PACK_WORDS-1: go to PK_HOLD, out_valid<=1, out_count<=PACK_WORDS, idx<=0.
//    - Latency: last word popped at edge N; out_valid high from edge N.
//  - PK_FILL, flush=1 at edge:
//    - If words held (idx + fifo_read) > 0: go to PK_HOLD with out_count = idx + fifo_read.
//      A word popped on the same edge is included. Unfilled lanes are driven to 0.
//    - If nothing is held and nothing is popped: flush is ignored and state stays in PK_FILL.
//  - PK_HOLD: out_valid=1. out_data and out_count are stable until handshake. No FIFO reads occur.
//    - Edge with out_ready=1: out_valid<=0, lanes cleared to 0, go to PK_FILL.
//    - flush in PK_HOLD is ignored and not remembered.
//  - Throughput is one beat per PACK_WORDS+1 cycles at best; the handshake cycle has no pop.
//  - fifo_empty rising mid-fill: stall in PK_FILL with idx held; no timeout.
//  - idx never exceeds PACK_WORDS-1 in PK_FILL; out_count is never 0 while out_valid==1.
// STRUCTURE
//  - Shared package asyn_fifo_pkg:
//    - typedef enum logic {PK_FILL, PK_HOLD} rd_pack_state_t
//    - localparam default DATA_BITS
//  - No sub-module. Lane register array, idx counter and 2-state FSM are all local.
//  - Connects directly to asyn_fifo_interface read-side signals (empty, read, output_data).
// TESTING
//  1 Reset, FIFO holds 0x001..0x004 -> 4 pops in 4 cycles; out_data=0x004_003_002_001 (10b
//    lanes), out_count=4, out_valid high the cycle after the 4th pop.
//  2 out_ready held 0 for 10 cycles with FIFO non-empty -> fifo_read stays 0; out_data stable;
//    ready=1 -> out_valid drops next edge.
//  3 Pop 0x3FF, 0x155, then flush=1 with fifo_empty=1 -> out_count=2,
//    out_data=0x000_000_155_3FF.
//  4 Flush on same edge as pop of 3rd word -> out_count=3, that word in lane 2.
//    Flush with idx=0 and FIFO empty -> no beat.
//  5 r_reset asserted after 2 words packed -> out_valid=0, idx=0. Next 4 words form a clean beat
//    with no stale lanes.
//  6 Random FIFO empty gaps and random out_ready, 1000 words -> scoreboard sees in-order,
//    lossless, duplicate-free words.

Source files
------------

// File: rtl/asyn_fifo_pkg.sv
// rtl/asyn_fifo_pkg.sv - shared types and defaults for the asynchronous FIFO slice
package asyn_fifo_pkg;

  localparam int DEFAULT_DATA_BITS = 10;

  typedef enum logic {PK_FILL, PK_HOLD} rd_pack_state_t;

endpackage

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs FWFT FIFO words into wide valid/ready beats
module fifo_rd_packer
  import asyn_fifo_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int PACK_WORDS = 4,
  parameter int CNT_BITS   = $clog2(PACK_WORDS + 1)
) (
  input  logic                            r_clk,
  input  logic                            r_reset,
  input  logic                            fifo_empty,
  output logic                            fifo_read,
  input  logic [DATA_BITS-1:0]            fifo_data,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_BITS*PACK_WORDS-1:0] out_data,
  output logic [CNT_BITS-1:0]             out_count
);

  rd_pack_state_t state, state_nxt;

  logic [PACK_WORDS-1:0][DATA_BITS-1:0] lanes;
  logic [CNT_BITS-1:0]                  idx;
  logic [CNT_BITS-1:0]                  held;
  logic                                 last_word;
  logic                                 begin_hold;
  logic                                 handshake;

  assign fifo_read = (state == PK_FILL) & ~fifo_empty & ~r_reset;
  // A word popped on the flush edge counts toward the partial beat.
  assign held      = idx + CNT_BITS'(fifo_read);
  assign last_word = fifo_read && (idx == CNT_BITS'(PACK_WORDS - 1));
  assign handshake = (state == PK_HOLD) && out_ready;
  assign out_data  = lanes;

  always_comb begin
    state_nxt  = state;
    begin_hold = 1'b0;
    case (state)
      PK_FILL: begin
        if (last_word || (flush && (held != '0))) begin
          state_nxt  = PK_HOLD;
          begin_hold = 1'b1;
        end
      end
      PK_HOLD: begin
        if (out_ready) begin
          state_nxt = PK_FILL;
        end
      end
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (r_reset) begin
      state <= PK_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge r_clk) begin
    if (r_reset) begin
      idx       <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      lanes     <= '0;
    end else begin
      if (fifo_read) begin
        for (int i = 0; i < PACK_WORDS; i++) begin
          if (idx == CNT_BITS'(i)) begin
            lanes[i] <= fifo_data;
          end
        end
        idx <= idx + 1'b1;
      end
      if (begin_hold) begin
        out_valid <= 1'b1;
        out_count <= held;
        idx       <= '0;
      end
      // Lanes return to zero so a later partial beat pads with zeros.
      if (handshake) begin
        out_valid <= 1'b0;
        out_count <= '0;
        lanes     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - scoreboard bench for fifo_rd_packer
module tb_fifo_rd_packer;

  localparam int DW = 10;
  localparam int PW = 4;
  localparam int CW = $clog2(PW + 1);

  logic           r_clk = 1'b0;
  logic           r_reset;
  logic           fifo_empty;
  logic           fifo_read;
  logic [DW-1:0]  fifo_data;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [DW*PW-1:0] out_data;
  logic [CW-1:0]  out_count;

  fifo_rd_packer #(.DATA_BITS(DW), .PACK_WORDS(PW)) dut (
    .r_clk      (r_clk),
    .r_reset    (r_reset),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .fifo_data  (fifo_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count)
  );

  always #5 r_clk = ~r_clk;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] pend_q[$];
  logic          gap;
  int            n_checks;
  int            n_errors;
  int            words_rx;
  int            beats_rx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = gap || (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  // One clock: sample settled signals before the edge, update the FIFO model after it.
  task automatic tick();
    logic popped;
    logic [DW-1:0] pword;
    logic was_reset;
    int cnt;
    refresh();
    #1;
    popped    = fifo_read;
    pword     = fifo_data;
    was_reset = r_reset;
    if (out_valid) check("no_pop_in_hold", {63'd0, fifo_read}, 64'd0);
    if (out_valid && out_ready) begin
      cnt = int'(out_count);
      beats_rx++;
      check("count_range", {63'd0, (cnt >= 1 && cnt <= PW)}, 64'd1);
      for (int i = 0; i < PW; i++) begin
        if (i < cnt) begin
          if (pend_q.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
          end else begin
            check("lane_data", {54'd0, out_data[i*DW +: DW]}, {54'd0, pend_q.pop_front()});
            words_rx++;
          end
        end else begin
          check("lane_pad", {54'd0, out_data[i*DW +: DW]}, 64'd0);
        end
      end
    end
    @(posedge r_clk);
    #1;
    if (popped) begin
      void'(fifo_q.pop_front());
      pend_q.push_back(pword);
    end
    if (was_reset) pend_q.delete();
    refresh();
  endtask

  initial begin
    logic [DW*PW-1:0] stable_data;
    logic [DW-1:0]    w3;
    int pushed;
    int cyc;
    n_checks = 0;
    n_errors = 0;
    words_rx = 0;
    beats_rx = 0;
    gap       = 1'b0;
    r_reset   = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    refresh();

    // Reset with words already waiting: no pops allowed.
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    tick();
    tick();
    #1;
    check("rst_fifo_read", {63'd0, fifo_read}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {24'd0, out_data}, 64'd0);
    check("rst_out_count", {61'd0, out_count}, 64'd0);

    // Test 1: four back-to-back pops form a full beat.
    r_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      refresh();
      #1;
      check("t1_pop", {63'd0, fifo_read}, 64'd1);
      check("t1_valid_low", {63'd0, out_valid}, 64'd0);
      tick();
    end
    check("t1_valid", {63'd0, out_valid}, 64'd1);
    check("t1_data", {24'd0, out_data}, {24'd0, 10'h004, 10'h003, 10'h002, 10'h001});
    check("t1_count", {61'd0, out_count}, 64'd4);

    // Test 2: backpressure holds the beat and blocks reads.
    for (int i = 5; i <= 8; i++) push_word(DW'(i));
    stable_data = out_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_no_read", {63'd0, fifo_read}, 64'd0);
      check("t2_stable", {24'd0, out_data}, {24'd0, stable_data});
    end
    out_ready = 1'b1;
    tick();
    check("t2_valid_drop", {63'd0, out_valid}, 64'd0);
    cyc = 0;
    while ((fifo_q.size() != 0 || out_valid) && cyc < 50) begin
      tick();
      cyc++;
    end
    check("t2_drain", {63'd0, (cyc < 50)}, 64'd1);
    out_ready = 1'b0;

    // Test 3: flush with empty FIFO emits a two-word beat.
    push_word(10'h3FF);
    push_word(10'h155);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_valid", {63'd0, out_valid}, 64'd1);
    check("t3_count", {61'd0, out_count}, 64'd2);
    check("t3_data", {24'd0, out_data}, {24'd0, 10'h000, 10'h000, 10'h155, 10'h3FF});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Test 4: flush coinciding with the third pop includes that word.
    push_word(10'h0A1);
    push_word(10'h0B2);
    tick();
    tick();
    w3 = 10'h2C3;
    push_word(w3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_count", {61'd0, out_count}, 64'd3);
    check("t4_lane2", {54'd0, out_data[2*DW +: DW]}, {54'd0, w3});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    check("t4_empty_flush", {63'd0, out_valid}, 64'd0);

    // Test 5: reset mid-beat discards packed words.
    push_word(10'h111);
    push_word(10'h222);
    tick();
    tick();
    r_reset = 1'b1;
    tick();
    r_reset = 1'b0;
    check("t5_valid", {63'd0, out_valid}, 64'd0);
    check("t5_data_clr", {24'd0, out_data}, 64'd0);
    for (int i = 0; i < 4; i++) push_word(DW'(10'h300 + i));
    for (int i = 0; i < 4; i++) tick();
    check("t5_valid_beat", {63'd0, out_valid}, 64'd1);
    check("t5_count", {61'd0, out_count}, 64'd4);
    check("t5_data", {24'd0, out_data}, {24'd0, 10'h303, 10'h302, 10'h301, 10'h300});
    out_ready = 1'b1;
    tick();

    // Test 6: random gaps, backpressure and flushes over 1000 words.
    words_rx = 0;
    pushed   = 0;
    cyc      = 0;
    while (cyc < 20000 && (pushed < 1000 || fifo_q.size() != 0 || pend_q.size() != 0 || out_valid)) begin
      if (pushed < 1000 && $urandom_range(0, 2) != 0) begin
        push_word(DW'($urandom));
        pushed++;
      end
      gap       = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      flush     = ($urandom_range(0, 15) == 0) || (pushed == 1000 && fifo_q.size() == 0);
      tick();
      cyc++;
    end
    gap   = 1'b0;
    flush = 1'b0;
    check("t6_timeout", {63'd0, (cyc < 20000)}, 64'd1);
    check("t6_words", 64'(words_rx), 64'd1000);
    check("t6_pend_empty", 64'(pend_q.size()), 64'd0);
    check("t6_fifo_empty", 64'(fifo_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
